// File: rtl/tilemap_write_arbiter.sv
// Tilemap write arbiter: two requesters (A = game logic, B = animation) share
// one write port into a registered tilemap. Writes happen only while the
// display is blanked. A whole-map clear fills one row per blank cycle.
// Optional build macro TILEMAP_RANGE_CHECK_EN: drop transfers with an
// out-of-range coordinate or tile ID and pulse err on the following cycle.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | arbitrate A/B writes while blank=1; clr_req starts a clear
// CLEAR | one row per blank cycle is filled with DEFAULT_TILE; no grants
module tilemap_write_arbiter #(
  parameter int NUM_TILES_X    = 40,
  parameter int NUM_TILES_Y    = 25,
  parameter int TILE_IDX_WIDTH = 5,
  parameter int MAX_TILE_ID    = 21,
  parameter int DEFAULT_TILE   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      blank,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [5:0]                a_x,
  input  logic [4:0]                a_y,
  input  logic [TILE_IDX_WIDTH-1:0] a_id,
  input  logic                      b_valid,
  output logic                      b_ready,
  input  logic [5:0]                b_x,
  input  logic [4:0]                b_y,
  input  logic [TILE_IDX_WIDTH-1:0] b_id,
  input  logic                      clr_req,
  output logic                      clr_busy,
  output logic                      err,
  output logic [0:NUM_TILES_Y-1][0:NUM_TILES_X-1][TILE_IDX_WIDTH-1:0] tilemap
);

  localparam int ROW_W = (NUM_TILES_Y > 1) ? $clog2(NUM_TILES_Y) : 1;
  localparam logic [TILE_IDX_WIDTH-1:0] FILL     = TILE_IDX_WIDTH'(DEFAULT_TILE);
  localparam logic [ROW_W-1:0]          LAST_ROW = ROW_W'(NUM_TILES_Y - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                    state, state_nxt;
  logic [ROW_W-1:0]          row;
  logic                      last_b;
  logic                      grant_a, grant_b;
  logic                      xfer;
  logic [5:0]                wr_x;
  logic [4:0]                wr_y;
  logic [TILE_IDX_WIDTH-1:0] wr_id;
  logic                      coord_ok, id_ok;
  logic                      wr_en;
  logic                      clear_en;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state: a clear starts on clr_req and ends after the last row is filled.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (blank && (row == LAST_ROW)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: round-robin grant in IDLE; reset forces both readys low.
  always_comb begin
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    clr_busy = (state == CLEAR);
    if (rst && (state == IDLE) && blank && !clr_req) begin
      if (a_valid && b_valid) begin
        grant_a = last_b;
        grant_b = !last_b;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign xfer     = grant_a | grant_b;
  assign wr_x     = grant_a ? a_x  : b_x;
  assign wr_y     = grant_a ? a_y  : b_y;
  assign wr_id    = grant_a ? a_id : b_id;
  assign coord_ok = (int'(wr_x) < NUM_TILES_X) && (int'(wr_y) < NUM_TILES_Y);
  assign id_ok    = (int'(wr_id) <= MAX_TILE_ID);
  assign clear_en = (state == CLEAR) && blank;

`ifdef TILEMAP_RANGE_CHECK_EN
  assign wr_en = xfer && coord_ok && id_ok;

  // Dropped transfer is reported one cycle after it was accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= 1'b0;
    else      err <= xfer && !(coord_ok && id_ok);
  end
`else
  logic unused_id_check;
  assign unused_id_check = id_ok;
  assign wr_en           = xfer && coord_ok;
  assign err             = 1'b0;
`endif

  // Clear row counter and round-robin pointer (moves only on accepted transfers).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row    <= '0;
      last_b <= 1'b1;
    end else begin
      if (state == IDLE)    row <= '0;
      else if (blank)       row <= (row == LAST_ROW) ? '0 : row + ROW_W'(1);
      if (xfer)             last_b <= grant_b;
    end
  end

  // Tilemap storage: row fill during a clear, single-cell write otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_TILES_Y; r++)
        for (int c = 0; c < NUM_TILES_X; c++)
          tilemap[r][c] <= FILL;
    end else begin
      for (int r = 0; r < NUM_TILES_Y; r++)
        for (int c = 0; c < NUM_TILES_X; c++)
          if (clear_en && (row == ROW_W'(r)))
            tilemap[r][c] <= FILL;
          else if (wr_en && (wr_y == 5'(r)) && (wr_x == 6'(c)))
            tilemap[r][c] <= wr_id;
    end
  end

endmodule

// File: tb/tb_tilemap_write_arbiter.sv
// Bench for tilemap_write_arbiter: fixed vector table, directed multi-cycle
// sequences (stall, clear, range handling, reset mid-clear) and a randomized
// phase compared against a behavioural tilemap model.
module tb_tilemap_write_arbiter;
  localparam int NX = 40;
  localparam int NY = 25;
  localparam int W  = 5;
  localparam int MAXID = 21;

  logic clk = 1'b0;
  logic rst, blank, a_valid, a_ready, b_valid, b_ready, clr_req, clr_busy, err;
  logic [5:0] a_x, b_x;
  logic [4:0] a_y, b_y;
  logic [W-1:0] a_id, b_id;
  logic [0:NY-1][0:NX-1][W-1:0] tilemap;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tilemap_write_arbiter dut (
    .clk(clk), .rst(rst), .blank(blank),
    .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_y(a_y), .a_id(a_id),
    .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_y(b_y), .b_id(b_id),
    .clr_req(clr_req), .clr_busy(clr_busy), .err(err), .tilemap(tilemap)
  );

  // behavioural model state
  int mm [NY][NX];
  bit m_clear;
  int m_row;
  bit m_last_b;

  typedef struct {
    bit bl; bit av; int ax; int ay; int aid;
    bit bv; int bx; int by; int bid; bit cr;
    bit ear; bit ebr; int cy; int cx; int cval;
  } vec_t;
  vec_t vt [7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit bl, input bit av, input int ax, input int ay, input int aid,
                        input bit bv, input int bx, input int by, input int bid, input bit cr);
    blank = bl; a_valid = av; a_x = 6'(ax); a_y = 5'(ay); a_id = W'(aid);
    b_valid = bv; b_x = 6'(bx); b_y = 5'(by); b_id = W'(bid); clr_req = cr;
  endtask

  task automatic check_map_zero(input string name);
    int n = 0;
    for (int y = 0; y < NY; y++)
      for (int x = 0; x < NX; x++)
        if (tilemap[y][x] !== '0) n++;
    chk(name, n, 0);
  endtask

  task automatic check_map_model(input string name);
    int n = 0;
    for (int y = 0; y < NY; y++)
      for (int x = 0; x < NX; x++)
        if (int'(tilemap[y][x]) != mm[y][x]) n++;
    chk(name, n, 0);
  endtask

  task automatic model_reset();
    for (int y = 0; y < NY; y++)
      for (int x = 0; x < NX; x++)
        mm[y][x] = 0;
    m_clear = 0; m_row = 0; m_last_b = 1;
  endtask

  // One clock of the model: returns readys/busy for this cycle and err for the next.
  task automatic model_step(input bit bl, input bit av, input int ax, input int ay, input int aid,
                            input bit bv, input int bx, input int by, input int bid, input bit cr,
                            output bit ear, output bit ebr, output bit ebusy, output bit eerr);
    bit pick_a;
    int x, y, id;
    bit in_range;
    ear = 0; ebr = 0; ebusy = m_clear; eerr = 0;
    if (m_clear) begin
      if (bl) begin
        for (int c = 0; c < NX; c++) mm[m_row][c] = 0;
        m_row++;
        if (m_row == NY) begin m_clear = 0; m_row = 0; end
      end
    end else if (cr) begin
      m_clear = 1; m_row = 0;
    end else if (bl && (av || bv)) begin
      pick_a = av && (!bv || m_last_b);
      ear = pick_a; ebr = !pick_a;
      m_last_b = !pick_a;
      x = pick_a ? ax : bx; y = pick_a ? ay : by; id = pick_a ? aid : bid;
      in_range = (x < NX) && (y < NY);
`ifdef TILEMAP_RANGE_CHECK_EN
      if (in_range && id <= MAXID) mm[y][x] = id;
      else eerr = 1;
`else
      if (in_range) mm[y][x] = id;
`endif
    end
  endtask

  initial begin
    bit done;
    int blank_cnt;
    bit pa, pb;
    int pax, pay, paid, pbx, pby, pbid;
    bit rbl, rcr, ear, ebr, ebusy, eerr;

    // reset with requests present: readys must stay low
    rst = 1'b0;
    set_in(1, 1, 1, 1, 3, 1, 2, 2, 4, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_err", err, 0);
    check_map_zero("rst_map");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // vector table: blank, A payload, B payload, clr_req -> readys and a cell after the edge
    vt[0] = '{1, 1, 3, 2, 5, 1, 3, 2, 9, 0, 1, 0, 2, 3, 5};
    vt[1] = '{1, 1, 3, 2, 5, 1, 3, 2, 9, 0, 0, 1, 2, 3, 9};
    vt[2] = '{1, 1, 3, 2, 5, 0, 0, 0, 0, 0, 1, 0, 2, 3, 5};
    vt[3] = '{0, 1, 0, 0, 7, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0};
    vt[4] = '{1, 1, 0, 0, 7, 1, 1, 1, 3, 0, 0, 1, 1, 1, 3};
    vt[5] = '{1, 1, 0, 0, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 7};
    vt[6] = '{1, 1, 0, 0, 9, 1, 4, 4, 9, 1, 0, 0, 0, 0, 7};
    for (int i = 0; i < 7; i++) begin
      set_in(vt[i].bl, vt[i].av, vt[i].ax, vt[i].ay, vt[i].aid,
             vt[i].bv, vt[i].bx, vt[i].by, vt[i].bid, vt[i].cr);
      #1;
      chk($sformatf("vec%0d_a_ready", i), a_ready, vt[i].ear);
      chk($sformatf("vec%0d_b_ready", i), b_ready, vt[i].ebr);
      tick();
      chk($sformatf("vec%0d_cell", i), tilemap[vt[i].cy][vt[i].cx], vt[i].cval);
    end

    // clear in progress: blank toggles every 5 cycles, A stalls, a second clr_req is ignored
    done = 0; blank_cnt = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      set_in(((c / 5) % 2) == 1, 1, 0, 0, 7, 0, 0, 0, 0, c == 7);
      #1;
      if (!clr_busy) done = 1;
      else begin
        if (blank) blank_cnt++;
        chk("clr_a_stall", a_ready, 0);
        tick();
      end
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("clr_done", done, 1);
    chk("clr_blank_cycles", blank_cnt, NY);
    check_map_zero("clr_map_zero");

    // request held through 10 non-blank cycles, accepted as soon as blank rises
    for (int c = 0; c < 10; c++) begin
      set_in(0, 1, 0, 0, 7, 0, 0, 0, 0, 0);
      #1;
      chk("stall_a_ready", a_ready, 0);
      tick();
    end
    set_in(1, 1, 0, 0, 7, 0, 0, 0, 0, 0);
    #1;
    chk("blank_rise_a_ready", a_ready, 1);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("blank_rise_cell", tilemap[0][0], 7);

    // corner cell with illegal ID, then out-of-range column
    set_in(1, 1, 39, 24, 22, 0, 0, 0, 0, 0);
    #1;
    chk("corner_a_ready", a_ready, 1);
    tick();
`ifdef TILEMAP_RANGE_CHECK_EN
    chk("corner_err", err, 1);
    chk("corner_cell", tilemap[24][39], 0);
`else
    chk("corner_err", err, 0);
    chk("corner_cell", tilemap[24][39], 22);
`endif
    set_in(1, 1, 40, 0, 3, 0, 0, 0, 0, 0);
    #1;
    chk("oor_a_ready", a_ready, 1);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef TILEMAP_RANGE_CHECK_EN
    chk("oor_err", err, 1);
`else
    chk("oor_err", err, 0);
`endif
    chk("oor_cell00", tilemap[0][0], 7);
    chk("oor_cell01", tilemap[0][1], 0);
    tick();
    chk("err_clears", err, 0);

    // reset in the middle of a clear
    set_in(1, 1, 5, 20, 4, 0, 0, 0, 0, 0);
    tick();
    chk("pre_rst_cell", tilemap[20][5], 4);
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (12) tick();
    chk("mid_clr_busy", clr_busy, 1);
    chk("mid_clr_row20", tilemap[20][5], 4);
    set_in(1, 1, 2, 0, 3, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", clr_busy, 0);
    chk("rst_mid_a_ready", a_ready, 0);
    check_map_zero("rst_mid_map");
    tick();
    rst = 1'b1;
    #1;
    chk("post_rst_a_ready", a_ready, 1);
    tick();
    set_in(1, 1, 2, 24, 3, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("restart_row0", tilemap[0][2], 0);
    chk("restart_row24_kept", tilemap[24][2], 3);
    repeat (NY - 1) tick();
    chk("restart_done_busy", clr_busy, 0);
    chk("restart_row24", tilemap[24][2], 0);

    // randomized traffic against the model
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    model_reset();
    pa = 0; pb = 0;
    pax = 0; pay = 0; paid = 0; pbx = 0; pby = 0; pbid = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pa && $urandom_range(1, 0) == 1) begin
        pa = 1; pax = $urandom_range(43, 0); pay = $urandom_range(26, 0); paid = $urandom_range(31, 0);
      end
      if (!pb && $urandom_range(1, 0) == 1) begin
        pb = 1; pbx = $urandom_range(43, 0); pby = $urandom_range(26, 0); pbid = $urandom_range(31, 0);
      end
      rbl = ($urandom_range(3, 0) != 0);
      rcr = ($urandom_range(59, 0) == 0);
      set_in(rbl, pa, pax, pay, paid, pb, pbx, pby, pbid, rcr);
      model_step(rbl, pa, pax, pay, paid, pb, pbx, pby, pbid, rcr, ear, ebr, ebusy, eerr);
      #1;
      chk("rnd_a_ready", a_ready, ear);
      chk("rnd_b_ready", b_ready, ebr);
      chk("rnd_clr_busy", clr_busy, ebusy);
      if (ear) pa = 0;
      if (ebr) pb = 0;
      tick();
      chk("rnd_err", err, eerr);
      if (c % 100 == 99) check_map_model("rnd_map");
    end
    check_map_model("rnd_map_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
